// File: rtl/mw_adder_sequencer.sv
// Wide-integer add/subtract unit that time-shares one N-bit carry-lookahead slice, LSB slice first.
// Optional feature: define MW_ADDER_SATURATE_EN to saturate the result on signed overflow.
module mw_adder_sequencer #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic             sub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N*WORDS-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int W    = N * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cin_q, cin_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            overflow_q, overflow_d;

  logic [N-1:0]    slice_a, slice_b, slice_sum;
  logic [N-1:0]    g, p;
  logic [N:0]      c_vec;
  logic [1:0]      c_out;
  logic            acc, prod;

  assign slice_a = a_q[idx_q*N +: N];
  assign slice_b = b_q[idx_q*N +: N];

  // Carry-lookahead slice: every carry is a flat sum of generate/propagate products.
  // c_out[1] is the carry out of the slice MSB, c_out[0] the carry into it.
  always_comb begin
    g        = slice_a & slice_b;
    p        = slice_a ^ slice_b;
    c_vec    = '0;
    c_vec[0] = cin_q;
    acc      = 1'b0;
    prod     = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      acc        = acc | (prod & cin_q);
      c_vec[i+1] = acc;
    end
    slice_sum = p ^ c_vec[N-1:0];
    c_out     = {c_vec[N], c_vec[N-1]};
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    cin_d      = cin_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          cin_d   = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = slice_sum;
        cin_d               = c_out[1];
        if (idx_q == LAST_IDX) begin
          carry_d    = c_out[1];
          overflow_d = c_out[1] ^ c_out[0];
`ifdef MW_ADDER_SATURATE_EN
          if (c_out[1] ^ c_out[0]) begin
            sum_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      cin_q      <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      cin_q      <= cin_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign sum        = sum_q;
  assign carry      = carry_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mw_adder_sequencer.sv
// Directed self-checking bench for mw_adder_sequencer (N=16, WORDS=4).
module tb_mw_adder_sequencer;

  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         busy;

  int pass_count = 0;
  int fail_count = 0;
  int total_count = 0;
  int cycles;
  logic [W-1:0] held_sum;

  mw_adder_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .sub(sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one request at an IDLE cycle, then counts edges until resp_valid (bounded).
  task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                               input logic op_sub, output int lat);
    a = op_a; b = op_b; sub = op_sub; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input int lat, input logic [W-1:0] exp_sum,
                             input logic exp_c, input logic exp_o);
    checkOutput({tag, " latency"}, W'(lat), W'(WORDS));
    checkOutput({tag, " resp_valid"}, W'(resp_valid), W'(1));
    checkOutput({tag, " sum"}, sum, exp_sum);
    checkOutput({tag, " carry"}, W'(carry), W'(exp_c));
    checkOutput({tag, " overflow"}, W'(overflow), W'(exp_o));
  endtask

  task automatic releaseResponse(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput({tag, " back to idle"}, W'(req_ready), W'(1));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; a = '0; b = '0; sub = 1'b0; resp_ready = 1'b0;
    #12;
    checkOutput("reset req_ready", W'(req_ready), W'(1));
    checkOutput("reset resp_valid", W'(resp_valid), W'(0));
    checkOutput("reset busy", W'(busy), W'(0));
    checkOutput("reset sum", sum, '0);
    checkOutput("reset carry", W'(carry), W'(0));
    checkOutput("reset overflow", W'(overflow), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, cycles);
    checkResult("t1 ripple", cycles, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    checkOutput("t1 busy in DONE", W'(busy), W'(1));
    releaseResponse("t1");

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, cycles);
    checkResult("t2 carry out", cycles, 64'h0, 1'b1, 1'b0);
    releaseResponse("t2");

    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, cycles);
`ifdef MW_ADDER_SATURATE_EN
    checkResult("t3 overflow", cycles, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
`else
    checkResult("t3 overflow", cycles, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
`endif
    releaseResponse("t3");

    applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b1, cycles);
`ifdef MW_ADDER_SATURATE_EN
    checkResult("t3b sub overflow", cycles, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
`else
    checkResult("t3b sub overflow", cycles, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
`endif
    releaseResponse("t3b");

    applyStimulus(64'd5, 64'd7, 1'b1, cycles);
    checkResult("t4 5-7", cycles, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    releaseResponse("t4a");
    applyStimulus(64'd7, 64'd5, 1'b1, cycles);
    checkResult("t4 7-5", cycles, 64'd2, 1'b1, 1'b0);
    releaseResponse("t4b");

    applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, cycles);
    checkResult("t5 op", cycles, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
    held_sum = 64'h1234_5678_9ABC_DF00;
    a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; sub = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("t5 stall sum", sum, held_sum);
      checkOutput("t5 stall carry", W'(carry), W'(0));
      checkOutput("t5 stall overflow", W'(overflow), W'(0));
      checkOutput("t5 stall req_ready", W'(req_ready), W'(0));
      checkOutput("t5 stall resp_valid", W'(resp_valid), W'(1));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    checkOutput("t5 exit to idle", W'(busy), W'(0));
    checkOutput("t5 exit req_ready", W'(req_ready), W'(1));
    checkOutput("t5 exit resp_valid", W'(resp_valid), W'(0));
    checkOutput("t5 sum kept", sum, held_sum);
    @(posedge clk); #1;
    checkOutput("t5 no capture", W'(busy), W'(0));

    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checkOutput("t6 rst req_ready", W'(req_ready), W'(1));
    checkOutput("t6 rst resp_valid", W'(resp_valid), W'(0));
    checkOutput("t6 rst busy", W'(busy), W'(0));
    checkOutput("t6 rst sum", sum, '0);
    checkOutput("t6 rst carry", W'(carry), W'(0));
    checkOutput("t6 rst overflow", W'(overflow), W'(0));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(64'd1, 64'd1, 1'b0, cycles);
    checkResult("t6 after reset", cycles, 64'd2, 1'b0, 1'b0);
    releaseResponse("t6");

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/mw_adder_sequencer.md
Name: mw_adder_sequencer

Overview:
- Multi-cycle wide-integer add/subtract unit for the ALU. It performs one operation on WORDS*N-bit operands by time-sharing a single N-bit lookAheadCarryAdder slice, one slice per cycle, LSB slice first.
- Carry is chained between cycles through a register.
- Sits between the ALU control and wide-operand consumers, using a valid/ready handshake on both request and response sides.

Parameters:
- N, 16, width of the shared adder slice in bits.
- WORDS, 4, number of slices per operand; WORDS >= 1; total width W = N*WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- a  input  W  operand A, two's complement.
- b  input  W  operand B, two's complement.
- sub  input  1  1 = A-B, 0 = A+B.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- carry  output  1  carry out of the MSB (for subtract: 1 = no borrow).
- overflow  output  1  signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock domain. rst is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, busy=0, sum=0, carry=0, overflow=0, slice index=0, internal carry=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: capture a; capture b, or ~b if sub=1; internal carry <= sub; idx <= 0; go to RUN.
- RUN:
  - req_ready=0. Each cycle the slice adds a_reg[idx*N +: N] + b_reg[idx*N +: N] + internal carry.
  - The result is written to sum[idx*N +: N], and internal carry <= c_out[1].
  - When idx == WORDS-1: carry <= c_out[1]; overflow <= c_out[1] ^ c_out[0]; go to DONE. Otherwise idx <= idx+1.
- DONE:
  - resp_valid=1. sum, carry and overflow are held stable.
  - On resp_ready=1 at an edge: go to IDLE and drop resp_valid. Outputs keep their last value until the next result overwrites them.
- Latency:
  - Request accepted at edge T gives resp_valid high after edge T+WORDS.
  - Minimum request-to-request interval is WORDS+2 cycles with resp_ready tied high.
- Handshake rules:
  - req_valid is ignored while not in IDLE, and a/b/sub are not sampled there.
  - No request is accepted in the same cycle that DONE is exited; IDLE must be entered first.
- The sum register is only partially updated during RUN. Consumers must sample sum only while resp_valid=1.
- Arithmetic is modulo 2^W. Subtract is implemented as A + ~B + 1 through the slice carry-in.
- WORDS=1: RUN lasts exactly one cycle.
- Asynchronous reset in RUN or DONE aborts the operation immediately. All outputs return to their reset values and the in-flight result is discarded. The first request is accepted at the first edge after rst deasserts.
- busy = (state != IDLE).

Optional Feature:
- Macro: MW_ADDER_SATURATE_EN.
- Defined: when overflow is detected on the last slice, sum is replaced at the DONE transition. It becomes 2^(W-1)-1 if a_reg[W-1]=0, or -2^(W-1) if a_reg[W-1]=1. overflow still reads 1, and carry is unchanged.
- Undefined: the result wraps modulo 2^W, and no saturation logic is synthesised.

Test Plan:
- Test 1, add carry ripple across slices:
  - Stimulus: N=16, WORDS=4; add 0x0000_0000_0000_FFFF + 0x1.
  - Response: sum=0x0000_0000_0001_0000, carry=0, overflow=0; resp_valid rises exactly 4 edges after acceptance.
- Test 2, full-width carry out:
  - Stimulus: add 0xFFFF_FFFF_FFFF_FFFF + 0x1.
  - Response: sum=0, carry=1, overflow=0.
- Test 3, signed overflow:
  - Stimulus: add 0x7FFF_FFFF_FFFF_FFFF + 0x1.
  - Response: sum=0x8000_0000_0000_0000, overflow=1. With MW_ADDER_SATURATE_EN: sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Test 4, subtract with borrow:
  - Stimulus: sub 5 - 7.
  - Response: sum=0xFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0. Then sub 7 - 5 gives sum=2, carry=1.
- Test 5, response backpressure:
  - Stimulus: hold resp_ready=0 for 3 cycles in DONE while pulsing req_valid with new operands.
  - Response: sum/carry/overflow stay stable, req_ready=0, the new request is not captured, and the unit returns to IDLE one edge after resp_ready=1.
- Test 6, reset mid-operation:
  - Stimulus: assert rst asynchronously while in RUN with idx=2.
  - Response: all outputs immediately at reset values and req_ready=1. A following request 1+1 yields sum=2 with no residue from the aborted operation.
